// File: rtl/calc_operand_ctrl.sv
// Calculator front-end: conditions four push buttons, sequences operand and mode capture for the add/sub datapath, and latches its result.
// Optional build macro CALC_OVERFLOW_FLAG_EN adds the o_ovf signed-overflow output.
module calc_operand_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_sw,
  input  logic       i_btn_load,
  input  logic       i_btn_add,
  input  logic       i_btn_sub,
  input  logic       i_btn_clear,
  input  logic [3:0] i_sum,
  input  logic       i_c,
  output logic [3:0] o_a,
  output logic [3:0] o_b,
  output logic       o_mode,
  output logic [3:0] o_result,
  output logic       o_carry,
  output logic       o_valid,
  output logic [2:0] o_state
`ifdef CALC_OVERFLOW_FLAG_EN
  ,
  output logic       o_ovf
`endif
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_OP = 3'd1,
    GET_B  = 3'd2,
    CALC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  localparam int unsigned BTN_LOAD  = 0;
  localparam int unsigned BTN_ADD   = 1;
  localparam int unsigned BTN_SUB   = 2;
  localparam int unsigned BTN_CLEAR = 3;

  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [3:0]       btn_raw_s;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       stable_q, stable_d;
  logic [3:0]       stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       pulse_s;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       mode_q, mode_d;
  logic [3:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;
  logic       ovf_calc_s;

  assign btn_raw_s = {i_btn_clear, i_btn_sub, i_btn_add, i_btn_load};
  assign pulse_s   = stable_q & ~stable_dly_q;

  // Button synchroniser, debounce counter and stable-level update.
  always_comb begin
    sync1_d      = btn_raw_s;
    sync2_d      = sync1_q;
    stable_dly_d = stable_q;
    stable_d     = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (sync2_q[i] != stable_q[i]) begin
        if ((cnt_q[i] + CNT_ONE) == DB_LIMIT) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = CNT_ZERO;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = CNT_ZERO;
      end
    end
  end

  // Button conditioning registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q      <= 4'd0;
      sync2_q      <= 4'd0;
      stable_q     <= 4'd0;
      stable_dly_q <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Signed overflow of the adder's current operation, sampled only in CALC.
  always_comb begin
    if (mode_q) begin
      ovf_calc_s = (a_q[3] != b_q[3]) && (i_sum[3] != a_q[3]);
    end else begin
      ovf_calc_s = (a_q[3] == b_q[3]) && (i_sum[3] != a_q[3]);
    end
  end

  // Sequencer next-state and datapath register updates; clear dominates every other pulse.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    if (pulse_s[BTN_CLEAR]) begin
      state_d  = GET_A;
      a_d      = 4'd0;
      b_d      = 4'd0;
      mode_d   = 1'b0;
      result_d = 4'd0;
      carry_d  = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          if (pulse_s[BTN_LOAD]) begin
            a_d     = i_sw;
            state_d = GET_OP;
          end else begin
            state_d = GET_A;
          end
        end
        GET_OP: begin
          if (pulse_s[BTN_ADD]) begin
            mode_d  = 1'b0;
            state_d = GET_B;
          end else if (pulse_s[BTN_SUB]) begin
            mode_d  = 1'b1;
            state_d = GET_B;
          end else begin
            state_d = GET_OP;
          end
        end
        GET_B: begin
          if (pulse_s[BTN_LOAD]) begin
            b_d     = i_sw;
            state_d = CALC;
          end else begin
            state_d = GET_B;
          end
        end
        CALC: begin
          result_d = i_sum;
          carry_d  = i_c;
          ovf_d    = ovf_calc_s;
          state_d  = SHOW;
        end
        SHOW: begin
          if (pulse_s[BTN_LOAD]) begin
            a_d     = result_q;
            b_d     = 4'd0;
            state_d = GET_OP;
          end else begin
            state_d = SHOW;
          end
        end
        default: begin
          state_d = GET_A;
        end
      endcase
    end
    valid_d = (state_d == SHOW);
  end

  // Sequencer and result registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= GET_A;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      mode_q   <= 1'b0;
      result_q <= 4'd0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_a      = a_q;
  assign o_b      = b_q;
  assign o_mode   = mode_q;
  assign o_result = result_q;
  assign o_carry  = carry_q;
  assign o_valid  = valid_q;
  assign o_state  = state_q;

`ifdef CALC_OVERFLOW_FLAG_EN
  assign o_ovf = ovf_q;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_q;
`endif

endmodule

// File: tb/tb_calc_operand_ctrl.sv
// Self-checking bench for calc_operand_ctrl with a behavioural calculator model and a 4-bit add/sub adder.
module tb_calc_operand_ctrl;

  localparam int unsigned DB   = 4;
  localparam int          HOLD = 10;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic [3:0] i_sw = 4'd0;
  logic       i_btn_load = 1'b0, i_btn_add = 1'b0, i_btn_sub = 1'b0, i_btn_clear = 1'b0;
  logic [3:0] i_sum;
  logic       i_c;
  logic [3:0] o_a, o_b, o_result;
  logic       o_mode, o_carry, o_valid;
  logic [2:0] o_state;
`ifdef CALC_OVERFLOW_FLAG_EN
  logic       o_ovf;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  calc_operand_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_sw(i_sw),
    .i_btn_load(i_btn_load), .i_btn_add(i_btn_add), .i_btn_sub(i_btn_sub), .i_btn_clear(i_btn_clear),
    .i_sum(i_sum), .i_c(i_c),
    .o_a(o_a), .o_b(o_b), .o_mode(o_mode), .o_result(o_result), .o_carry(o_carry),
    .o_valid(o_valid), .o_state(o_state)
`ifdef CALC_OVERFLOW_FLAG_EN
    , .o_ovf(o_ovf)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Downstream 4-bit adder: subtract is a + ~b + 1, carry-out = no borrow.
  logic [4:0] add5, sub5;
  assign add5  = {1'b0, o_a} + {1'b0, o_b};
  assign sub5  = {1'b0, o_a} + {1'b0, ~o_b} + 5'd1;
  assign i_sum = o_mode ? sub5[3:0] : add5[3:0];
  assign i_c   = o_mode ? sub5[4] : add5[4];

  // Behavioural model of the calculator, advanced once per button press.
  int         m_state;
  logic [3:0] m_a, m_b, m_res;
  logic       m_mode, m_carry, m_ovf;

  task automatic model_reset();
    m_state = 0; m_a = 4'd0; m_b = 4'd0; m_res = 4'd0;
    m_mode = 1'b0; m_carry = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_press(input logic ld, input logic ad, input logic sb, input logic cl,
                             input logic [3:0] sw);
    int ua, ub, sa, sbv, sres;
    if (cl) begin
      model_reset();
    end else if (m_state == 0 && ld) begin
      m_a = sw; m_state = 1;
    end else if (m_state == 1 && (ad || sb)) begin
      m_mode = ad ? 1'b0 : 1'b1; m_state = 2;
    end else if (m_state == 2 && ld) begin
      m_b = sw;
      ua = int'(m_a); ub = int'(m_b);
      sa = (ua > 7) ? ua - 16 : ua;
      sbv = (ub > 7) ? ub - 16 : ub;
      if (m_mode) begin
        m_res = 4'((ua - ub + 16) % 16); m_carry = (ua >= ub); sres = sa - sbv;
      end else begin
        m_res = 4'((ua + ub) % 16); m_carry = (ua + ub > 15); sres = sa + sbv;
      end
      m_ovf = (sres > 7) || (sres < -8);
      m_state = 4;
    end else if (m_state == 4 && ld) begin
      m_a = m_res; m_b = 4'd0; m_state = 1;
    end
  endtask

  function automatic logic [17:0] exp_vec();
    return {3'(m_state), m_a, m_b, m_mode, m_res, m_carry, (m_state == 4)};
  endfunction

  logic [17:0] dut_vec;
  assign dut_vec = {o_state, o_a, o_b, o_mode, o_result, o_carry, o_valid};

  task automatic press(input logic ld, input logic ad, input logic sb, input logic cl,
                       input logic [3:0] sw);
    @(negedge i_clk);
    i_sw = sw; i_btn_load = ld; i_btn_add = ad; i_btn_sub = sb; i_btn_clear = cl;
    repeat (HOLD) @(negedge i_clk);
    i_btn_load = 1'b0; i_btn_add = 1'b0; i_btn_sub = 1'b0; i_btn_clear = 1'b0;
    repeat (HOLD) @(negedge i_clk);
    model_press(ld, ad, sb, cl, sw);
  endtask

  task automatic test_reset();
    tests_run++;
    if (dut_vec !== 18'd0) begin
      tests_failed++; $display("FAIL reset_init: got %h expected %h", dut_vec, 18'd0);
    end
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tests_run++;
    if (o_state !== 3'd2 || o_a !== 4'd5) begin
      tests_failed++; $display("FAIL reset_setup: got state %0d a %0d expected 2 5", o_state, o_a);
    end
    @(negedge i_clk); #2 i_reset_n = 1'b0; #1;
    tests_run++;
    if (dut_vec !== 18'd0) begin
      tests_failed++; $display("FAIL reset_async: got %h expected %h", dut_vec, 18'd0);
    end
`ifdef CALC_OVERFLOW_FLAG_EN
    tests_run++;
    if (o_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ovf: got %b expected 0", o_ovf);
    end
`endif
    @(negedge i_clk); i_reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_add();
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    tests_run++;
    if (dut_vec !== exp_vec() || o_result !== 4'd7 || o_state !== 3'd4 || o_valid !== 1'b1) begin
      tests_failed++; $display("FAIL add_3_4: got %h expected %h (result 7 state 4)", dut_vec, exp_vec());
    end
  endtask

  task automatic test_sub_ovf();
    press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    press(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    tests_run++;
    if (dut_vec !== exp_vec() || o_result !== 4'hD || o_carry !== 1'b0 || o_mode !== 1'b1) begin
      tests_failed++; $display("FAIL sub_2_5: got %h expected %h (result D carry 0)", dut_vec, exp_vec());
    end
`ifdef CALC_OVERFLOW_FLAG_EN
    tests_run++;
    if (o_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL sub_ovf: got %b expected 0", o_ovf);
    end
`endif
    press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd7);
    press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    tests_run++;
    if (dut_vec !== exp_vec() || o_result !== 4'd8) begin
      tests_failed++; $display("FAIL add_7_1: got %h expected %h", dut_vec, exp_vec());
    end
`ifdef CALC_OVERFLOW_FLAG_EN
    tests_run++;
    if (o_ovf !== 1'b1) begin
      tests_failed++; $display("FAIL add_ovf: got %b expected 1", o_ovf);
    end
`endif
  endtask

  task automatic test_debounce();
    press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge i_clk); i_sw = 4'd6; i_btn_load = 1'b1;
    repeat (3) @(negedge i_clk);
    i_btn_load = 1'b0;
    repeat (HOLD) @(negedge i_clk);
    tests_run++;
    if (dut_vec !== exp_vec() || o_state !== 3'd2) begin
      tests_failed++; $display("FAIL short_glitch: got %h expected %h", dut_vec, exp_vec());
    end
    i_btn_load = 1'b1;
    repeat (2) @(negedge i_clk);
    i_btn_load = 1'b0;
    @(negedge i_clk);
    i_btn_load = 1'b1;
    repeat (20) @(negedge i_clk);
    i_btn_load = 1'b0;
    repeat (HOLD) @(negedge i_clk);
    model_press(1'b1, 1'b0, 1'b0, 1'b0, 4'd6);
    tests_run++;
    if (dut_vec !== exp_vec() || o_state !== 3'd4) begin
      tests_failed++; $display("FAIL held_one_pulse: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_chain();
    press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    tests_run++;
    if (dut_vec !== exp_vec() || o_a !== 4'd7 || o_b !== 4'd0 || o_state !== 3'd1) begin
      tests_failed++; $display("FAIL chain_load: got %h expected %h", dut_vec, exp_vec());
    end
    press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    tests_run++;
    if (dut_vec !== exp_vec() || o_result !== 4'd0 || o_carry !== 1'b1) begin
      tests_failed++; $display("FAIL chain_wrap: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    press(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tests_run++;
    if (dut_vec !== exp_vec() || o_mode !== 1'b0 || o_state !== 3'd2) begin
      tests_failed++; $display("FAIL add_sub_same: got %h expected %h", dut_vec, exp_vec());
    end
    press(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    press(1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
    tests_run++;
    if (dut_vec !== 18'd0 || dut_vec !== exp_vec()) begin
      tests_failed++; $display("FAIL clear_load_same: got %h expected %h", dut_vec, 18'd0);
    end
  endtask

  task automatic test_random();
    int op;
    logic [3:0] sw;
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 9));
      sw = 4'($urandom_range(0, 15));
      case (op)
        0, 1, 2: press(1'b1, 1'b0, 1'b0, 1'b0, sw);
        3, 4:    press(1'b0, 1'b1, 1'b0, 1'b0, sw);
        5, 6:    press(1'b0, 1'b0, 1'b1, 1'b0, sw);
        7:       press(1'b0, 1'b0, 1'b0, 1'b1, sw);
        8:       press(1'b0, 1'b1, 1'b1, 1'b0, sw);
        default: press(1'b1, 1'b1, 1'b0, 1'b1, sw);
      endcase
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++; $display("FAIL random_%0d op %0d: got %h expected %h", n, op, dut_vec, exp_vec());
      end
`ifdef CALC_OVERFLOW_FLAG_EN
      tests_run++;
      if (o_ovf !== m_ovf) begin
        tests_failed++; $display("FAIL random_ovf_%0d: got %b expected %b", n, o_ovf, m_ovf);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    test_reset();
    test_add();
    test_sub_ovf();
    test_debounce();
    test_chain();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
